voice_sequencer: RTL and testbench

- Parametrised next-generation voice scheduler and mixer for TT6581. Sits between the register file and the shared voice generator.
- On each sample tick it walks NUM_VOICES voices in turn and drives each voice's parameters to the generator with a start/ready handshake. Disabled voices are skipped, and a hung generator is recovered by timeout.
- Converts each raw voice sample to signed, accumulates, applies a master volume, and presents the mixed sample on a valid/ready output port.

---
 rtl/voice_sequencer.sv | 179 +++++++++++++++++
 tb/tb_voice_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_sequencer.sv
// Voice scheduler and mixer: walks NUM_VOICES voices per sample tick, accumulates
// signed samples, applies master volume. Define VOICE_SEQ_SATURATE_EN to clamp instead of wrap.
module voice_sequencer #(
    parameter int NUM_VOICES  = 3,
    parameter int WAVE_W      = 10,
    parameter int OUT_W       = 16,
    parameter int OUT_SHIFT   = 0,
    parameter int TIMEOUT_CYC = 255,
    localparam int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
    localparam int ACC_W      = WAVE_W + 1 + $clog2(NUM_VOICES)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           sample_tick_i,
    input  logic [NUM_VOICES-1:0][7:0]     freq_lo_i,
    input  logic [NUM_VOICES-1:0][7:0]     freq_hi_i,
    input  logic [NUM_VOICES-1:0][7:0]     pw_lo_i,
    input  logic [NUM_VOICES-1:0][7:0]     pw_hi_i,
    input  logic [NUM_VOICES-1:0][7:0]     control_i,
    input  logic [NUM_VOICES-1:0]          voice_en_i,
    input  logic [3:0]                     master_vol_i,
    input  logic                           voice_ready_i,
    input  logic [WAVE_W-1:0]              voice_wave_i,
    output logic                           voice_start_o,
    output logic [IDX_W-1:0]               voice_idx_o,
    output logic [15:0]                    voice_freq_o,
    output logic [11:0]                    voice_pw_o,
    output logic [3:0]                     voice_wave_o,
    output logic                           audio_valid_o,
    input  logic                           audio_ready_i,
    output logic [OUT_W-1:0]               audio_o,
    output logic                           overrun_o,
    output logic                           timeout_o,
    input  logic                           flags_clr_i
);

    localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int PROD_W = ACC_W + 5;
    localparam int RES_W  = PROD_W + OUT_SHIFT + OUT_W + 1;
    localparam int MID    = 2 ** (WAVE_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_SCALE = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic signed [ACC_W-1:0]  r_acc;
    logic [IDX_W-1:0]         r_idx;
    logic [CNT_W-1:0]         r_cnt;
    logic [OUT_W-1:0]         r_audio;
    logic                     r_overrun;
    logic                     r_timeout;

    logic                     w_last;
    logic                     w_en;
    logic                     w_expired;
    logic                     w_done;
    logic                     w_to_event;
    logic                     w_ov_event;
    logic signed [ACC_W-1:0]  w_term;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [RES_W-1:0]  w_shift;
    logic [OUT_W-1:0]         w_result;
    logic                     w_unused;

    assign w_last     = (r_idx == IDX_W'(NUM_VOICES - 1));
    assign w_en       = voice_en_i[r_idx];
    assign w_expired  = (r_cnt == '0);
    assign w_done     = (r_state == S_WAIT) && (voice_ready_i || w_expired);
    assign w_to_event = (r_state == S_WAIT) && !voice_ready_i && w_expired;
    assign w_ov_event = sample_tick_i && (r_state != S_IDLE);

    // Raw generator samples are offset-binary; re-centre around zero.
    assign w_term  = $signed({{(ACC_W-WAVE_W){1'b0}}, voice_wave_i}) - $signed(ACC_W'(MID));
    assign w_prod  = PROD_W'(r_acc) * PROD_W'($signed({1'b0, master_vol_i}));
    assign w_shift = RES_W'(w_prod) <<< OUT_SHIFT;

`ifdef VOICE_SEQ_SATURATE_EN
    logic [RES_W-OUT_W:0] w_upper;
    assign w_upper = w_shift[RES_W-1:OUT_W-1];
    always_comb begin
        if ((&w_upper) || !(|w_upper)) begin
            w_result = w_shift[OUT_W-1:0];
        end else if (w_shift[RES_W-1]) begin
            w_result = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            w_result = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    assign w_result = OUT_W'(w_shift);
`endif

    assign voice_idx_o  = r_idx;
    assign voice_freq_o = {freq_hi_i[r_idx], freq_lo_i[r_idx]};
    assign voice_pw_o   = {pw_hi_i[r_idx][3:0], pw_lo_i[r_idx]};
    assign voice_wave_o = control_i[r_idx][7:4];
    assign audio_o      = r_audio;
    assign overrun_o    = r_overrun;
    assign timeout_o    = r_timeout;
    assign w_unused     = &{1'b0, control_i, pw_hi_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (sample_tick_i) w_next = S_START;
            S_START: begin
                if (w_en)        w_next = S_WAIT;
                else if (w_last) w_next = S_SCALE;
            end
            S_WAIT: begin
                if (w_done) w_next = w_last ? S_SCALE : S_START;
            end
            S_SCALE: w_next = S_OUT;
            S_OUT:   if (audio_ready_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        voice_start_o = 1'b0;
        audio_valid_o = 1'b0;
        case (r_state)
            S_START: voice_start_o = w_en;
            S_OUT:   audio_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc     <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_audio   <= '0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sample_tick_i) begin
                        r_acc <= '0;
                        r_idx <= '0;
                    end
                end
                S_START: begin
                    if (w_en)         r_cnt <= CNT_W'(TIMEOUT_CYC - 1);
                    else if (!w_last) r_idx <= r_idx + IDX_W'(1);
                end
                S_WAIT: begin
                    if (voice_ready_i)   r_acc <= r_acc + w_term;
                    else if (!w_expired) r_cnt <= r_cnt - CNT_W'(1);
                    if (w_done && !w_last) r_idx <= r_idx + IDX_W'(1);
                end
                S_SCALE: r_audio <= w_result;
                default: ;
            endcase
            // A set event in the clear cycle keeps the flag high.
            if (w_ov_event)       r_overrun <= 1'b1;
            else if (flags_clr_i) r_overrun <= 1'b0;
            if (w_to_event)       r_timeout <= 1'b1;
            else if (flags_clr_i) r_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_voice_sequencer.sv
// Randomized bench for voice_sequencer with a sum-of-voices reference model and
// an expected-sample queue.
module tb_voice_sequencer;

    localparam int NV        = 3;
    localparam int WAVE_W    = 10;
    localparam int OUT_W     = 16;
    localparam int OUT_SHIFT = 1;
    localparam int TO        = 4;
    localparam int IDX_W     = 2;

    logic                    clk_i;
    logic                    rst_ni;
    logic                    sample_tick_i;
    logic [NV-1:0][7:0]      freq_lo_i, freq_hi_i, pw_lo_i, pw_hi_i, control_i;
    logic [NV-1:0]           voice_en_i;
    logic [3:0]              master_vol_i;
    logic                    voice_ready_i;
    logic [WAVE_W-1:0]       voice_wave_i;
    logic                    voice_start_o;
    logic [IDX_W-1:0]        voice_idx_o;
    logic [15:0]             voice_freq_o;
    logic [11:0]             voice_pw_o;
    logic [3:0]              voice_wave_o;
    logic                    audio_valid_o;
    logic                    audio_ready_i;
    logic [OUT_W-1:0]        audio_o;
    logic                    overrun_o;
    logic                    timeout_o;
    logic                    flags_clr_i;

    voice_sequencer #(
        .NUM_VOICES (NV),
        .WAVE_W     (WAVE_W),
        .OUT_W      (OUT_W),
        .OUT_SHIFT  (OUT_SHIFT),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .sample_tick_i(sample_tick_i),
        .freq_lo_i    (freq_lo_i),
        .freq_hi_i    (freq_hi_i),
        .pw_lo_i      (pw_lo_i),
        .pw_hi_i      (pw_hi_i),
        .control_i    (control_i),
        .voice_en_i   (voice_en_i),
        .master_vol_i (master_vol_i),
        .voice_ready_i(voice_ready_i),
        .voice_wave_i (voice_wave_i),
        .voice_start_o(voice_start_o),
        .voice_idx_o  (voice_idx_o),
        .voice_freq_o (voice_freq_o),
        .voice_pw_o   (voice_pw_o),
        .voice_wave_o (voice_wave_o),
        .audio_valid_o(audio_valid_o),
        .audio_ready_i(audio_ready_i),
        .audio_o      (audio_o),
        .overrun_o    (overrun_o),
        .timeout_o    (timeout_o),
        .flags_clr_i  (flags_clr_i)
    );

    // Clock and reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int               n_checks = 0;
    int               n_errors = 0;
    logic [OUT_W-1:0] exp_q[$];
    bit               exp_ov = 0;
    bit               exp_to = 0;
    int               cur_wave[NV];
    int               cur_delay[NV];
    logic [NV-1:0]    cur_en;
    int               cur_vol;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Mixed sample = sum of centred samples * volume, shifted, then wrapped or clamped.
    function automatic logic [OUT_W-1:0] model_mix(input int sum, input int vol);
        longint v;
        v = longint'(sum) * longint'(vol) * (longint'(1) << OUT_SHIFT);
`ifdef VOICE_SEQ_SATURATE_EN
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
`endif
        return v[OUT_W-1:0];
    endfunction

    task automatic load_regs();
        for (int v = 0; v < NV; v++) begin
            freq_lo_i[v] = 8'($urandom);
            freq_hi_i[v] = 8'($urandom);
            pw_lo_i[v]   = 8'($urandom);
            pw_hi_i[v]   = 8'($urandom);
            control_i[v] = 8'($urandom);
        end
    endtask

    task automatic clear_flags();
        @(negedge clk_i);
        flags_clr_i = 1'b1;
        @(negedge clk_i);
        flags_clr_i = 1'b0;
        exp_ov = 0;
        exp_to = 0;
        check("clr_overrun", overrun_o, 0);
        check("clr_timeout", timeout_o, 0);
    endtask

    // One full sample: tick, serve the generator handshakes, check the mix and flags.
    task automatic run_sample(input int hold, input bit busy_tick, input bit busy_clr,
                              input bit out_tick, input bit done_tick);
        int               exp_lat, sum, k, wcnt, nstart, dly, pv, tick_at;
        bit               pending, seen, to_now;
        int               exp_vox[$];
        logic [OUT_W-1:0] held;
        sum = 0; exp_lat = 2; to_now = 0;
        for (int v = 0; v < NV; v++) begin
            if (cur_en[v]) begin
                exp_vox.push_back(v);
                if (cur_delay[v] >= 0 && cur_delay[v] < TO) begin
                    sum += cur_wave[v] - (1 << (WAVE_W - 1));
                    exp_lat += 2 + cur_delay[v];
                end else begin
                    exp_lat += 1 + TO;
                    to_now = 1;
                end
            end else begin
                exp_lat += 1;
            end
        end
        exp_q.push_back(model_mix(sum, cur_vol));
        tick_at = busy_tick ? $urandom_range(1, exp_lat - 1) : 0;
        voice_en_i   = cur_en;
        master_vol_i = 4'(cur_vol);
        @(negedge clk_i);
        sample_tick_i = 1'b1;
        audio_ready_i = 1'b0;
        @(negedge clk_i);
        sample_tick_i = 1'b0;
        k = 1; pending = 0; seen = 0; nstart = 0; wcnt = 0; dly = 0;
        while (!seen && k <= exp_lat + 4) begin
            if (audio_valid_o) begin
                seen = 1;
            end else begin
                if (pending) begin
                    if (dly == wcnt) begin
                        voice_ready_i = 1'b1;
                        voice_wave_i  = WAVE_W'(cur_wave[pv]);
                        pending = 0;
                    end else begin
                        voice_ready_i = 1'b0;
                        voice_wave_i  = WAVE_W'($urandom);
                        wcnt++;
                        if (wcnt >= TO) pending = 0;
                    end
                end else begin
                    // Ready outside WAIT must be ignored by the sequencer.
                    voice_ready_i = 1'($urandom_range(0, 1));
                    voice_wave_i  = WAVE_W'($urandom);
                end
                if (voice_start_o) begin
                    pv = 0;
                    if (nstart < exp_vox.size()) begin
                        pv = exp_vox[nstart];
                        check("start_idx", voice_idx_o, pv);
                        check("freq", voice_freq_o, {freq_hi_i[pv], freq_lo_i[pv]});
                        check("pw", voice_pw_o, {pw_hi_i[pv][3:0], pw_lo_i[pv]});
                        check("wave_sel", voice_wave_o, control_i[pv][7:4]);
                    end
                    pending = 1; wcnt = 0; dly = cur_delay[pv];
                    nstart++;
                end
                if (k == tick_at) begin
                    sample_tick_i = 1'b1;
                    exp_ov = 1;
                    flags_clr_i = busy_clr;
                    if (busy_clr) exp_to = 0;
                end else begin
                    sample_tick_i = 1'b0;
                    flags_clr_i = 1'b0;
                end
                @(negedge clk_i);
                k++;
            end
        end
        sample_tick_i = 1'b0;
        flags_clr_i   = 1'b0;
        voice_ready_i = 1'b0;
        if (to_now) exp_to = 1;
        check("latency", seen ? k : -1, exp_lat);
        check("start_count", nstart, exp_vox.size());
        held = exp_q.pop_front();
        check("audio", audio_o, held);
        for (int h = 0; h < hold; h++) begin
            sample_tick_i = (out_tick && h == 0);
            if (out_tick && h == 0) exp_ov = 1;
            check("hold_valid", audio_valid_o, 1);
            check("hold_audio", audio_o, held);
            @(negedge clk_i);
        end
        audio_ready_i = 1'b1;
        sample_tick_i = done_tick;
        if (done_tick) exp_ov = 1;
        @(negedge clk_i);
        audio_ready_i = 1'b0;
        sample_tick_i = 1'b0;
        check("valid_drop", audio_valid_o, 0);
        check("no_restart0", voice_start_o, 0);
        @(negedge clk_i);
        check("no_restart1", voice_start_o, 0);
        check("idle_valid", audio_valid_o, 0);
        check("overrun", overrun_o, exp_ov);
        check("timeout", timeout_o, exp_to);
    endtask

    task automatic reset_mid_wait();
        int k;
        cur_en = 3'b111;
        voice_en_i    = cur_en;
        master_vol_i  = 4'd15;
        voice_ready_i = 1'b1;
        voice_wave_i  = 10'h3ff;
        @(negedge clk_i);
        sample_tick_i = 1'b1;
        @(negedge clk_i);
        sample_tick_i = 1'b0;
        k = 0;
        while (!(voice_start_o && voice_idx_o == 2'd1) && k < 20) begin
            @(negedge clk_i);
            k++;
        end
        check("rst_reach_v1", k < 20, 1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        voice_ready_i = 1'b0;
        #1;
        check("rst_valid", audio_valid_o, 0);
        check("rst_audio", audio_o, 0);
        check("rst_start", voice_start_o, 0);
        check("rst_idx", voice_idx_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_timeout", timeout_o, 0);
        exp_ov = 0;
        exp_to = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic set_all(input logic [NV-1:0] en, input int wave, input int vol);
        cur_en = en;
        cur_vol = vol;
        for (int v = 0; v < NV; v++) begin
            cur_wave[v]  = wave;
            cur_delay[v] = 0;
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        sample_tick_i = 1'b0;
        voice_en_i = '0;
        master_vol_i = '0;
        voice_ready_i = 1'b0;
        voice_wave_i = '0;
        audio_ready_i = 1'b0;
        flags_clr_i = 1'b0;
        load_regs();
        repeat (3) @(negedge clk_i);
        check("reset_valid", audio_valid_o, 0);
        check("reset_audio", audio_o, 0);
        check("reset_start", voice_start_o, 0);
        check("reset_idx", voice_idx_o, 0);
        check("reset_overrun", overrun_o, 0);
        check("reset_timeout", timeout_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        set_all(3'b111, 1023, 15);
        run_sample(2, 0, 0, 0, 0);
        set_all(3'b111, 0, 15);
        run_sample(1, 0, 0, 0, 0);
        set_all(3'b010, 0, 1);
        run_sample(0, 0, 0, 0, 0);

        set_all(3'b111, 1023, 1);
        cur_delay[1] = -1;
        run_sample(1, 0, 0, 0, 0);
        clear_flags();

        set_all(3'b111, 700, 9);
        cur_delay[0] = 2; cur_delay[2] = 3;
        run_sample(20, 0, 0, 1, 1);
        set_all(3'b101, 300, 7);
        run_sample(0, 0, 0, 0, 0);

        reset_mid_wait();
        set_all(3'b111, 900, 5);
        run_sample(1, 0, 0, 0, 0);

        set_all(3'b000, 1023, 15);
        run_sample(0, 0, 0, 0, 0);
        set_all(3'b111, 1000, 0);
        run_sample(0, 0, 0, 0, 0);

        set_all(3'b111, 10, 3);
        cur_delay[0] = -1;
        run_sample(0, 0, 0, 0, 0);
        set_all(3'b011, 600, 4);
        run_sample(1, 1, 1, 0, 0);

        for (int n = 0; n < 40; n++) begin
            load_regs();
            cur_en  = NV'($urandom);
            cur_vol = $urandom_range(0, 15);
            for (int v = 0; v < NV; v++) begin
                cur_wave[v]  = $urandom_range(0, 1023);
                cur_delay[v] = ($urandom_range(0, 9) < 2) ? -1 : $urandom_range(0, TO - 1);
            end
            run_sample($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (n % 8 == 7) clear_flags();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
